rob_multiport: RTL and testbench
================================

# rob_multiport

Parametrised in-order-commit reorder buffer for the out-of-order RV32I core. It sits between the issue unit, the execution writeback channels (ALU, LSB, …) and the register file. It supports a configurable depth, a configurable number of writeback channels, operand lookup for the issue unit, store-commit handshaking with the LSB, and misprediction flush/redirect. It retires one instruction per cycle.

## Interface
- DEPTH, 16: entries; power of two, at least 4.
- IDX_W, $clog2(DEPTH): entry index width.
- NUM_WB, 2: writeback channels (channel 0 = ALU, 1 = LSB).
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- rdy  in  1  global enable; when 0, all state holds.
- issue_valid  in  1  allocate an entry at the tail.
- issue_type  in  2  NORMAL, BRANCH, JALR or STORE.
- issue_rd  in  5  destination register; 0 means no RF write.
- issue_pred_taken  in  1  predictor decision (BRANCH only).
- issue_pc  in  32  instruction PC.
- tail_index  out  IDX_W  index the next issue will receive.
- rob_full  out  1  count == DEPTH.
- q1_index, q2_index  in  IDX_W  operand lookup indices.
- q1_ready, q2_ready  out  1  looked-up entry has its value.
- q1_value, q2_value  out  32  looked-up entry value.
- wb_valid  in  NUM_WB  per-channel writeback strobe.
- wb_index  in  NUM_WB*IDX_W  per-channel entry index.
- wb_value  in  NUM_WB*32  result, or link value for JALR.
- wb_taken  in  NUM_WB  actual branch outcome.
- wb_target  in  NUM_WB*32  branch or JALR target.
- rf_valid, rf_rd, rf_value, rf_index  out  1/5/32/IDX_W  registered commit to the RF.
- lsb_commit_valid, lsb_commit_index  out  1/IDX_W  registered store-commit release.
- flush  out  1  registered pipeline flush.
- new_pc_enable, new_pc  out  1/32  registered fetch redirect.

## Operation
- Circular buffer with head, tail and count (IDX_W+1 bits). Indices wrap from DEPTH-1 to 0 by natural overflow.
- Per-entry state: busy, ready, type, rd, pred_taken, taken, pc, value, target.
- Issue: taken only when issue_valid && !rob_full && !flush. It writes the entry, clears ready, sets busy and increments tail. An issue while full is silently dropped.
- Writeback: for each channel with wb_valid, the entry's value, taken and target are written and ready is set. A writeback to a non-busy entry is ignored. Two channels writing the same index in one cycle is illegal; if it happens, the higher channel wins.
- Commit happens when head is busy and ready:
  - NORMAL or JALR: rf_valid=1 if rd≠0.
  - STORE: lsb_commit_valid=1 with rf_valid=0.
  - BRANCH with taken≠pred_taken: flush=1, new_pc_enable=1, new_pc = taken ? target : pc+4.
  - JALR: new_pc_enable=1, new_pc=target, no flush.
- Flush handling:
  - On a mispredicted commit, all busy bits clear and head, tail and count go to 0 at that same edge.
  - Any issue or writeback in that cycle is discarded.
  - While flush=1, issue_valid and wb_valid are ignored.
- Count update: issue+commit in the same cycle leaves count unchanged. Issue alone adds 1; commit alone subtracts 1.
- Outputs with no event present deassert to 0 on the next edge.

## Timing
- Reset (asynchronous, rst=0): head=tail=count=0, all busy/ready=0. All outputs 0 (rf_*, lsb_commit_*, flush, new_pc_enable, new_pc).
- Writeback at edge N makes the entry committable at edge N+1. Commit outputs are visible after edge N+1.
- Issue-to-commit takes at least 2 cycles.
- flush and new_pc_enable are single-cycle pulses.
- rob_full and tail_index are combinational from registered state.
- rdy=0 freezes all registers, including output pulses.

## Configuration
- ROB_BYPASS_EN defined:
  - q*_ready/q*_value also forward a same-cycle wb_valid to the matching index.
  - Lowest channel has priority over registered state.
- ROB_BYPASS_EN undefined:
  - Lookup reflects registered state only.
  - The issue unit must monitor the writeback bus itself.

## Structure
- Shared package: entry type encodings (ROB_NORMAL=0, ROB_BRANCH=1, ROB_JALR=2, ROB_STORE=3) and the default depth and channel count.
- One sub-module, rob_lookup: per-port combinational operand read plus the bypass mux, instantiated twice.

## Test plan
- Reset with rst=0 mid-run → all outputs 0 and rob_full=0 immediately, without waiting for a clock edge.
- Issue 16 NORMAL (DEPTH=16) → rob_full=1. A 17th issue is dropped. One commit then allows a new issue at index 0 (wrap-around).
- Writebacks arrive out of order (index 2, 0, 1) with values 0x22/0x00/0x11 → rf commits in order 0, 1, 2 on consecutive cycles.
- BRANCH with pred_taken=0, wb_taken=1, target 0x1000 → flush=1, new_pc=0x1000 for one cycle. Younger entries are never committed and count=0.
- JALR with wb_target 0x2004, rd=1 → rf_valid writes the link value, new_pc_enable=1, flush=0.
- ROB_BYPASS_EN: wb on channel 1 to index 5 while q1_index=5 → q1_ready=1 and q1_value correct in the same cycle. Without the macro, q1_ready=0 in that cycle.

Source files
------------

// File: rtl/rob_multiport_pkg.sv
// Shared definitions for the reorder buffer: entry type encodings and default sizing.
// Imported by rob_multiport and rob_lookup.
package rob_multiport_pkg;

  localparam int ROB_DEPTH_DEF  = 16;
  localparam int ROB_NUM_WB_DEF = 2;

  typedef enum logic [1:0] {
    ROB_NORMAL = 2'd0,
    ROB_BRANCH = 2'd1,
    ROB_JALR   = 2'd2,
    ROB_STORE  = 2'd3
  } rob_type_e;

  function automatic logic rob_writes_rf(input rob_type_e t, input logic [4:0] rd);
    return ((t == ROB_NORMAL) || (t == ROB_JALR)) && (rd != 5'd0);
  endfunction

endpackage

// File: rtl/rob_lookup.sv
// Combinational operand read of one ROB entry for the issue unit; zero latency, no backpressure.
// With ROB_BYPASS_EN defined, a same-cycle writeback to the looked-up index is forwarded (lowest channel wins).
module rob_lookup
  import rob_multiport_pkg::*;
#(
  parameter int DEPTH  = ROB_DEPTH_DEF,
  parameter int IDX_W  = $clog2(DEPTH),
  parameter int NUM_WB = ROB_NUM_WB_DEF
) (
  input  logic [IDX_W-1:0]        i_index,
  input  logic [DEPTH-1:0]        i_ready,
  input  logic [DEPTH*32-1:0]     i_value,
  input  logic [NUM_WB-1:0]       i_wb_valid,
  input  logic [NUM_WB*IDX_W-1:0] i_wb_index,
  input  logic [NUM_WB*32-1:0]    i_wb_value,
  output logic                    o_ready,
  output logic [31:0]             o_value
);

  always_comb begin
    o_ready = 1'b0;
    o_value = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i_index == IDX_W'(i)) begin
        o_ready = i_ready[i];
        o_value = i_value[i*32 +: 32];
      end
    end
`ifdef ROB_BYPASS_EN
    // Walk downwards so the lowest matching channel is the last assignment.
    for (int c = NUM_WB - 1; c >= 0; c--) begin
      if (i_wb_valid[c] && (i_wb_index[c*IDX_W +: IDX_W] == i_index)) begin
        o_ready = 1'b1;
        o_value = i_wb_value[c*32 +: 32];
      end
    end
`endif
  end

`ifndef ROB_BYPASS_EN
  logic w_unused_wb;
  assign w_unused_wb = ^{i_wb_valid, i_wb_index, i_wb_value};
`endif

endmodule

// File: rtl/rob_multiport.sv
// In-order-commit reorder buffer with NUM_WB writeback channels; optional lookup bypass via ROB_BYPASS_EN.
// Commit outputs are registered one edge after the head becomes ready; issue while full is dropped, rdy=0 freezes all.
module rob_multiport
  import rob_multiport_pkg::*;
#(
  parameter int DEPTH  = ROB_DEPTH_DEF,
  parameter int IDX_W  = $clog2(DEPTH),
  parameter int NUM_WB = ROB_NUM_WB_DEF
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_rdy,
  input  logic                    i_issue_valid,
  input  logic [1:0]              i_issue_type,
  input  logic [4:0]              i_issue_rd,
  input  logic                    i_issue_pred_taken,
  input  logic [31:0]             i_issue_pc,
  output logic [IDX_W-1:0]        o_tail_index,
  output logic                    o_rob_full,
  input  logic [IDX_W-1:0]        i_q1_index,
  input  logic [IDX_W-1:0]        i_q2_index,
  output logic                    o_q1_ready,
  output logic                    o_q2_ready,
  output logic [31:0]             o_q1_value,
  output logic [31:0]             o_q2_value,
  input  logic [NUM_WB-1:0]       i_wb_valid,
  input  logic [NUM_WB*IDX_W-1:0] i_wb_index,
  input  logic [NUM_WB*32-1:0]    i_wb_value,
  input  logic [NUM_WB-1:0]       i_wb_taken,
  input  logic [NUM_WB*32-1:0]    i_wb_target,
  output logic                    o_rf_valid,
  output logic [4:0]              o_rf_rd,
  output logic [31:0]             o_rf_value,
  output logic [IDX_W-1:0]        o_rf_index,
  output logic                    o_lsb_commit_valid,
  output logic [IDX_W-1:0]        o_lsb_commit_index,
  output logic                    o_flush,
  output logic                    o_new_pc_enable,
  output logic [31:0]             o_new_pc
);

  logic [IDX_W-1:0] r_head, r_tail;
  logic [IDX_W:0]   r_count;
  logic [DEPTH-1:0] r_busy, r_ready, r_pred, r_taken;
  rob_type_e        r_type   [DEPTH];
  logic [4:0]       r_rd     [DEPTH];
  logic [31:0]      r_pc     [DEPTH];
  logic [31:0]      r_value  [DEPTH];
  logic [31:0]      r_target [DEPTH];

  logic             r_rf_valid, r_lsb_commit_valid, r_flush, r_new_pc_enable;
  logic [4:0]       r_rf_rd;
  logic [31:0]      r_rf_value, r_new_pc;
  logic [IDX_W-1:0] r_rf_index, r_lsb_commit_index;

  logic [IDX_W-1:0]    w_wb_idx [NUM_WB];
  logic [NUM_WB-1:0]   w_wb_ok;
  logic [DEPTH*32-1:0] w_value_flat;
  logic                w_full, w_issue, w_commit, w_mispred, w_jalr, w_rf_we, w_store;
  rob_type_e           w_head_type;
  logic [31:0]         w_redirect;

  // Writebacks are dropped during the flush pulse and for entries not in flight.
  always_comb begin
    for (int c = 0; c < NUM_WB; c++) begin
      w_wb_idx[c] = i_wb_index[c*IDX_W +: IDX_W];
      w_wb_ok[c]  = i_wb_valid[c] && !r_flush && r_busy[w_wb_idx[c]];
    end
    for (int i = 0; i < DEPTH; i++) begin
      w_value_flat[i*32 +: 32] = r_value[i];
    end
  end

  assign w_full      = (r_count == (IDX_W+1)'(DEPTH));
  assign w_issue     = i_issue_valid && !w_full && !r_flush;
  assign w_commit    = r_busy[r_head] && r_ready[r_head];
  assign w_head_type = r_type[r_head];
  assign w_mispred   = w_commit && (w_head_type == ROB_BRANCH) && (r_taken[r_head] != r_pred[r_head]);
  assign w_jalr      = w_commit && (w_head_type == ROB_JALR);
  assign w_store     = w_commit && (w_head_type == ROB_STORE);
  assign w_rf_we     = w_commit && rob_writes_rf(w_head_type, r_rd[r_head]);
  assign w_redirect  = r_taken[r_head] ? r_target[r_head] : (r_pc[r_head] + 32'd4);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_head   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
      r_busy   <= '0;
      r_ready  <= '0;
      r_pred   <= '0;
      r_taken  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_type[i]   <= ROB_NORMAL;
        r_rd[i]     <= 5'd0;
        r_pc[i]     <= 32'd0;
        r_value[i]  <= 32'd0;
        r_target[i] <= 32'd0;
      end
      r_rf_valid         <= 1'b0;
      r_rf_rd            <= 5'd0;
      r_rf_value         <= 32'd0;
      r_rf_index         <= '0;
      r_lsb_commit_valid <= 1'b0;
      r_lsb_commit_index <= '0;
      r_flush            <= 1'b0;
      r_new_pc_enable    <= 1'b0;
      r_new_pc           <= 32'd0;
    end else if (i_rdy) begin
      r_rf_valid         <= w_rf_we;
      r_rf_rd            <= w_rf_we ? r_rd[r_head] : 5'd0;
      r_rf_value         <= w_rf_we ? r_value[r_head] : 32'd0;
      r_rf_index         <= w_rf_we ? r_head : '0;
      r_lsb_commit_valid <= w_store;
      r_lsb_commit_index <= w_store ? r_head : '0;
      r_flush            <= w_mispred;
      r_new_pc_enable    <= w_mispred || w_jalr;
      r_new_pc           <= w_mispred ? w_redirect : (w_jalr ? r_target[r_head] : 32'd0);

      if (w_mispred) begin
        r_busy  <= '0;
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        // Later (higher) channels overwrite earlier ones on an index collision.
        for (int c = 0; c < NUM_WB; c++) begin
          if (w_wb_ok[c]) begin
            r_value[w_wb_idx[c]]  <= i_wb_value[c*32 +: 32];
            r_taken[w_wb_idx[c]]  <= i_wb_taken[c];
            r_target[w_wb_idx[c]] <= i_wb_target[c*32 +: 32];
            r_ready[w_wb_idx[c]]  <= 1'b1;
          end
        end
        if (w_issue) begin
          r_busy[r_tail]  <= 1'b1;
          r_ready[r_tail] <= 1'b0;
          r_type[r_tail]  <= rob_type_e'(i_issue_type);
          r_rd[r_tail]    <= i_issue_rd;
          r_pred[r_tail]  <= i_issue_pred_taken;
          r_pc[r_tail]    <= i_issue_pc;
          r_tail          <= r_tail + 1'b1;
        end
        if (w_commit) begin
          r_busy[r_head] <= 1'b0;
          r_head         <= r_head + 1'b1;
        end
        case ({w_issue, w_commit})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  rob_lookup #(.DEPTH(DEPTH), .IDX_W(IDX_W), .NUM_WB(NUM_WB)) u_lookup_q1 (
    .i_index    (i_q1_index),
    .i_ready    (r_ready),
    .i_value    (w_value_flat),
    .i_wb_valid (w_wb_ok),
    .i_wb_index (i_wb_index),
    .i_wb_value (i_wb_value),
    .o_ready    (o_q1_ready),
    .o_value    (o_q1_value)
  );

  rob_lookup #(.DEPTH(DEPTH), .IDX_W(IDX_W), .NUM_WB(NUM_WB)) u_lookup_q2 (
    .i_index    (i_q2_index),
    .i_ready    (r_ready),
    .i_value    (w_value_flat),
    .i_wb_valid (w_wb_ok),
    .i_wb_index (i_wb_index),
    .i_wb_value (i_wb_value),
    .o_ready    (o_q2_ready),
    .o_value    (o_q2_value)
  );

  assign o_tail_index       = r_tail;
  assign o_rob_full         = w_full;
  assign o_rf_valid         = r_rf_valid;
  assign o_rf_rd            = r_rf_rd;
  assign o_rf_value         = r_rf_value;
  assign o_rf_index         = r_rf_index;
  assign o_lsb_commit_valid = r_lsb_commit_valid;
  assign o_lsb_commit_index = r_lsb_commit_index;
  assign o_flush            = r_flush;
  assign o_new_pc_enable    = r_new_pc_enable;
  assign o_new_pc           = r_new_pc;

endmodule

// File: tb/tb_rob_multiport.sv
// Bench for rob_multiport: queue-based reference model compared every cycle, plus directed literal checks.
// Works with or without ROB_BYPASS_EN.
module tb_rob_multiport;
  localparam int DEPTH = 16;
  localparam int IDX_W = 4;
  localparam int NUM_WB = 2;
`ifdef ROB_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b0, rdy = 1'b1;
  always #5 clk = ~clk;

  logic issue_valid = 0, issue_pred_taken = 0;
  logic [1:0] issue_type = 0;
  logic [4:0] issue_rd = 0;
  logic [31:0] issue_pc = 0;
  logic [IDX_W-1:0] tail_index, q1_index = 0, q2_index = 0;
  logic rob_full, q1_ready, q2_ready;
  logic [31:0] q1_value, q2_value;
  logic [NUM_WB-1:0] wb_valid = 0, wb_taken = 0;
  logic [NUM_WB*IDX_W-1:0] wb_index = 0;
  logic [NUM_WB*32-1:0] wb_value = 0, wb_target = 0;
  logic rf_valid, lsb_commit_valid, flush, new_pc_enable;
  logic [4:0] rf_rd;
  logic [31:0] rf_value, new_pc;
  logic [IDX_W-1:0] rf_index, lsb_commit_index;

  rob_multiport #(.DEPTH(DEPTH), .IDX_W(IDX_W), .NUM_WB(NUM_WB)) dut (
    .i_clk(clk), .i_rst(rst), .i_rdy(rdy),
    .i_issue_valid(issue_valid), .i_issue_type(issue_type), .i_issue_rd(issue_rd),
    .i_issue_pred_taken(issue_pred_taken), .i_issue_pc(issue_pc),
    .o_tail_index(tail_index), .o_rob_full(rob_full),
    .i_q1_index(q1_index), .i_q2_index(q2_index),
    .o_q1_ready(q1_ready), .o_q2_ready(q2_ready), .o_q1_value(q1_value), .o_q2_value(q2_value),
    .i_wb_valid(wb_valid), .i_wb_index(wb_index), .i_wb_value(wb_value),
    .i_wb_taken(wb_taken), .i_wb_target(wb_target),
    .o_rf_valid(rf_valid), .o_rf_rd(rf_rd), .o_rf_value(rf_value), .o_rf_index(rf_index),
    .o_lsb_commit_valid(lsb_commit_valid), .o_lsb_commit_index(lsb_commit_index),
    .o_flush(flush), .o_new_pc_enable(new_pc_enable), .o_new_pc(new_pc)
  );

  int total = 0, bad = 0, cyc = 0;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: in-flight instructions as an ordered queue, oldest first.
  typedef struct {
    logic [IDX_W-1:0] idx; logic [1:0] typ; logic [4:0] rd; logic pred; logic [31:0] pc;
    logic done; logic [31:0] value; logic taken; logic [31:0] target;
  } ent_t;
  ent_t mq[$];
  logic [IDX_W-1:0] mtail = 0;
  logic e_rfv = 0, e_lsbv = 0, e_flush = 0, e_npe = 0;
  logic [4:0] e_rd = 0;
  logic [31:0] e_rfval = 0, e_npc = 0;
  logic [IDX_W-1:0] e_rfidx = 0, e_lsbidx = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete(); mtail = 0;
      e_rfv = 0; e_rd = 0; e_rfval = 0; e_rfidx = 0; e_lsbv = 0; e_lsbidx = 0;
      e_flush = 0; e_npe = 0; e_npc = 0;
    end else if (rdy) begin : step_model
      ent_t h;
      logic com, mis, n_rfv, n_lsbv, n_npe;
      logic [31:0] n_npc;
      com = (mq.size() > 0) && mq[0].done;
      h = (mq.size() > 0) ? mq[0] : '{default: 0};
      n_rfv = com && (h.typ == 2'd0 || h.typ == 2'd2) && h.rd != 0;
      n_lsbv = com && h.typ == 2'd3;
      mis = com && h.typ == 2'd1 && h.taken != h.pred;
      n_npe = mis || (com && h.typ == 2'd2);
      n_npc = mis ? (h.taken ? h.target : h.pc + 4) : ((com && h.typ == 2'd2) ? h.target : 0);
      if (mis) begin
        mq.delete(); mtail = 0;
      end else begin
        if (!e_flush)
          for (int c = 0; c < NUM_WB; c++)
            if (wb_valid[c])
              foreach (mq[k])
                if (mq[k].idx == wb_index[c*IDX_W +: IDX_W]) begin
                  mq[k].done = 1; mq[k].value = wb_value[c*32 +: 32];
                  mq[k].taken = wb_taken[c]; mq[k].target = wb_target[c*32 +: 32];
                end
        if (issue_valid && !e_flush && mq.size() < DEPTH) begin
          mq.push_back('{mtail, issue_type, issue_rd, issue_pred_taken, issue_pc, 1'b0, 32'd0, 1'b0, 32'd0});
          mtail++;
        end
        if (com) void'(mq.pop_front());
      end
      e_rfv = n_rfv; e_rd = n_rfv ? h.rd : 0; e_rfval = n_rfv ? h.value : 0; e_rfidx = n_rfv ? h.idx : 0;
      e_lsbv = n_lsbv; e_lsbidx = n_lsbv ? h.idx : 0;
      e_flush = mis; e_npe = n_npe; e_npc = n_npc;
    end
  end

  task automatic mlook(input logic [IDX_W-1:0] qi, output logic found, output logic rd_o, output logic [31:0] val);
    found = 0; rd_o = 0; val = 0;
    foreach (mq[k]) if (mq[k].idx == qi) begin found = 1; rd_o = mq[k].done; val = mq[k].value; end
    if (BYP && found && !e_flush)
      for (int c = NUM_WB - 1; c >= 0; c--)
        if (wb_valid[c] && wb_index[c*IDX_W +: IDX_W] == qi) begin rd_o = 1; val = wb_value[c*32 +: 32]; end
  endtask

  typedef struct { int cyc; logic [IDX_W-1:0] idx; logic [31:0] val; logic [4:0] rd; } rflog_t;
  rflog_t rf_log[$];

  always @(negedge clk) begin
    if (rst) begin : cmp
      logic f, r; logic [31:0] v;
      check("rf_valid", rf_valid, e_rfv);
      check("rf_rd", rf_rd, e_rd);
      check("rf_value", rf_value, e_rfval);
      check("rf_index", rf_index, e_rfidx);
      check("lsb_valid", lsb_commit_valid, e_lsbv);
      check("lsb_index", lsb_commit_index, e_lsbidx);
      check("flush", flush, e_flush);
      check("new_pc_en", new_pc_enable, e_npe);
      check("new_pc", new_pc, e_npc);
      check("rob_full", rob_full, mq.size() == DEPTH);
      check("tail_index", tail_index, mtail);
      mlook(q1_index, f, r, v);
      if (f) begin check("q1_ready", q1_ready, r); if (r) check("q1_value", q1_value, v); end
      mlook(q2_index, f, r, v);
      if (f) begin check("q2_ready", q2_ready, r); if (r) check("q2_value", q2_value, v); end
      if (rf_valid) rf_log.push_back('{cyc, rf_index, rf_value, rf_rd});
    end
  end

  task automatic step();
    @(posedge clk); #1;
    issue_valid = 0; wb_valid = 0;
  endtask
  task automatic do_issue(input logic [1:0] t, input logic [4:0] rd, input logic pt, input logic [31:0] pc);
    issue_valid = 1; issue_type = t; issue_rd = rd; issue_pred_taken = pt; issue_pc = pc;
    step();
  endtask
  task automatic set_wb(input int ch, input logic [IDX_W-1:0] idx, input logic [31:0] v, input logic tk, input logic [31:0] tg);
    wb_valid[ch] = 1; wb_index[ch*IDX_W +: IDX_W] = idx; wb_value[ch*32 +: 32] = v;
    wb_taken[ch] = tk; wb_target[ch*32 +: 32] = tg;
  endtask
  task automatic do_wb(input int ch, input logic [IDX_W-1:0] idx, input logic [31:0] v, input logic tk, input logic [31:0] tg);
    set_wb(ch, idx, v, tk, tg);
    step();
  endtask
  task automatic pulse_reset();
    rst = 0; #2; rst = 1; step();
  endtask

  initial begin
    #1;
    check("por_rf_valid", rf_valid, 0);
    check("por_rob_full", rob_full, 0);
    check("por_tail", tail_index, 0);
    check("por_flush", flush, 0);
    check("por_new_pc", new_pc, 0);
    #3 rst = 1;
    step();

    // Out-of-order writebacks, in-order commits.
    do_issue(2'd0, 5'd1, 0, 32'h0);
    do_issue(2'd0, 5'd2, 0, 32'h4);
    do_issue(2'd0, 5'd3, 0, 32'h8);
    rf_log.delete();
    do_wb(0, 4'd2, 32'h22, 0, 0);
    do_wb(0, 4'd0, 32'h00, 0, 0);
    do_wb(1, 4'd1, 32'h11, 0, 0);
    repeat (4) step();
    check("ooo_count", rf_log.size(), 3);
    if (rf_log.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        check("ooo_index", rf_log[i].idx, i);
        check("ooo_rd", rf_log[i].rd, i + 1);
        check("ooo_value", rf_log[i].val, i * 32'h11);
      end
      check("ooo_consec1", rf_log[1].cyc - rf_log[0].cyc, 1);
      check("ooo_consec2", rf_log[2].cyc - rf_log[1].cyc, 1);
    end

    // Asynchronous reset mid-pulse.
    do_issue(2'd0, 5'd7, 0, 32'h40);
    do_wb(0, 4'd3, 32'h77, 0, 0);
    step();
    check("pre_rst_rf_valid", rf_valid, 1);
    check("pre_rst_rf_value", rf_value, 32'h77);
    rst = 0; #1;
    check("rst_rf_valid", rf_valid, 0);
    check("rst_rf_value", rf_value, 0);
    check("rst_rf_rd", rf_rd, 0);
    check("rst_tail", tail_index, 0);
    #1 rst = 1;
    step();

    // Fill, drop while full, wrap.
    for (int i = 0; i < DEPTH; i++) do_issue(2'd0, (i == 0) ? 5'd9 : 5'd0, 0, 32'(i * 4));
    check("full_after16", rob_full, 1);
    check("full_tail", tail_index, 0);
    do_issue(2'd0, 5'd0, 0, 32'h999);
    check("drop17_tail", tail_index, 0);
    check("drop17_full", rob_full, 1);
    do_wb(0, 4'd0, 32'h99, 0, 0);
    step();
    check("wrap_rf_valid", rf_valid, 1);
    check("wrap_rf_value", rf_value, 32'h99);
    check("wrap_not_full", rob_full, 0);
    do_issue(2'd0, 5'd0, 0, 32'h100);
    check("wrap_tail", tail_index, 1);
    check("wrap_full", rob_full, 1);
    rst = 0; #1;
    check("rst_full", rob_full, 0);
    #1 rst = 1;
    step();

    // Taken branch predicted not-taken: flush, younger entries dropped.
    rf_log.delete();
    do_issue(2'd1, 5'd0, 0, 32'h100);
    do_issue(2'd0, 5'd5, 0, 32'h104);
    do_issue(2'd0, 5'd6, 0, 32'h108);
    set_wb(0, 4'd1, 32'h5, 0, 0); set_wb(1, 4'd2, 32'h6, 0, 0); step();
    do_wb(0, 4'd0, 32'h0, 1, 32'h1000);
    step();
    check("br_flush", flush, 1);
    check("br_npe", new_pc_enable, 1);
    check("br_new_pc", new_pc, 32'h1000);
    check("br_tail", tail_index, 0);
    issue_valid = 1; issue_type = 0; issue_rd = 5'd8; issue_pc = 32'h10c;
    set_wb(0, 4'd0, 32'h3, 0, 0);
    step();
    check("br_flush_pulse", flush, 0);
    check("br_npe_pulse", new_pc_enable, 0);
    check("br_drop_tail", tail_index, 0);
    repeat (3) step();
    check("br_no_younger", rf_log.size(), 0);

    // JALR: link to RF and redirect without flush.
    do_issue(2'd2, 5'd1, 0, 32'h200);
    do_wb(0, 4'd0, 32'h204, 0, 32'h2004);
    step();
    check("jalr_rf_valid", rf_valid, 1);
    check("jalr_rf_rd", rf_rd, 1);
    check("jalr_rf_value", rf_value, 32'h204);
    check("jalr_npe", new_pc_enable, 1);
    check("jalr_new_pc", new_pc, 32'h2004);
    check("jalr_flush", flush, 0);
    step();
    check("jalr_npe_pulse", new_pc_enable, 0);

    // Store release.
    do_issue(2'd3, 5'd0, 0, 32'h300);
    do_wb(1, 4'd1, 32'hdead, 0, 0);
    step();
    check("st_lsb_valid", lsb_commit_valid, 1);
    check("st_lsb_index", lsb_commit_index, 1);
    check("st_rf_valid", rf_valid, 0);

    // Correctly predicted branch, then not-taken mispredict.
    do_issue(2'd1, 5'd0, 1, 32'h500);
    do_wb(0, 4'd2, 0, 1, 32'h600);
    step();
    check("brok_flush", flush, 0);
    check("brok_npe", new_pc_enable, 0);
    do_issue(2'd1, 5'd0, 1, 32'h400);
    do_wb(0, 4'd3, 0, 0, 32'h700);
    step();
    check("brnt_flush", flush, 1);
    check("brnt_new_pc", new_pc, 32'h404);
    step();

    // rdy=0 freezes pulses and pointers.
    do_issue(2'd0, 5'd4, 0, 32'h800);
    do_wb(0, 4'd0, 32'h44, 0, 0);
    step();
    rdy = 0;
    do_issue(2'd0, 5'd3, 0, 32'h804);
    step();
    check("hold_rf_valid", rf_valid, 1);
    check("hold_rf_value", rf_value, 32'h44);
    check("hold_tail", tail_index, 1);
    rdy = 1;
    step();
    check("unhold_rf_valid", rf_valid, 0);

    // Lookup with and without bypass; same-index collision.
    pulse_reset();
    for (int i = 0; i < 6; i++) do_issue(2'd0, 5'd0, 0, 32'(i * 4));
    q1_index = 4'd5; q2_index = 4'd4;
    set_wb(1, 4'd5, 32'h55, 0, 0);
    #3;
    check("byp_q1_ready", q1_ready, BYP);
    check("byp_q1_value", q1_value, BYP ? 32'h55 : 32'h0);
    check("byp_q2_ready", q2_ready, 0);
    step();
    check("reg_q1_ready", q1_ready, 1);
    check("reg_q1_value", q1_value, 32'h55);
    set_wb(0, 4'd4, 32'hA0, 0, 0); set_wb(1, 4'd4, 32'hB1, 0, 0);
    #3;
    check("coll_q2_ready", q2_ready, BYP);
    check("coll_q2_value", q2_value, BYP ? 32'hA0 : 32'h0);
    step();
    check("coll_reg_value", q2_value, 32'hB1);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time=%0t limit=100000", $time);
    $fatal(1);
  end

endmodule
